// File: rtl/reg_arb_pkg.sv
// rtl/reg_arb_pkg.sv - shared state encoding, widths and helpers for reg_write_arbiter
package reg_arb_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GRANT = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;

    localparam int HOLD_W = 4;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin pick starting one past last_id
module rr_pick
    import reg_arb_pkg::*;
#(
    parameter  int NREQ = 4,
    localparam int ID_W = clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [ID_W-1:0] last_id,
    output logic [ID_W-1:0] winner,
    output logic            any_req
);

    int              idx;
    logic [ID_W-1:0] cand;
    logic            found;

    always_comb begin
        winner  = '0;
        any_req = |req;
        found   = 1'b0;
        idx     = 0;
        cand    = '0;
        // Offset 1 first so the previous winner is visited last.
        for (int k = 1; k <= NREQ; k++) begin
            idx  = (int'(last_id) + k) % NREQ;
            cand = ID_W'(idx);
            if (!found && req[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/reg_write_arbiter.sv
// rtl/reg_write_arbiter.sv - round-robin writer for a shared enable-less data register
// Defining REG_ARB_STATS_EN adds per-requester saturating grant counters.
module reg_write_arbiter
    import reg_arb_pkg::*;
#(
    parameter  int                NREQ     = 4,
    parameter  int                DATA_W   = 32,
    parameter  int                HOLD_CYC = 2,
    parameter  logic [DATA_W-1:0] RST_VAL  = '0,
    localparam int                ID_W     = clog2(NREQ)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*DATA_W-1:0]   data_in,
`ifdef REG_ARB_STATS_EN
    input  logic                     stats_clr,
    output logic [NREQ*16-1:0]       grant_cnt,
`endif
    output logic [NREQ-1:0]          gnt,
    output logic [DATA_W-1:0]        reg_data,
    output logic                     reg_valid,
    output logic                     busy,
    output logic [ID_W-1:0]          last_id
);

    logic [1:0]        state_q, state_d;
    logic [ID_W-1:0]   win_q, win_d;
    logic [ID_W-1:0]   last_q, last_d;
    logic [HOLD_W-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0] data_q, data_d;

    logic [ID_W-1:0]   pick_win;
    logic              pick_any;

    rr_pick #(.NREQ(NREQ)) u_pick (
        .req     (req),
        .last_id (last_q),
        .winner  (pick_win),
        .any_req (pick_any)
    );

    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    win_d   = pick_win;
                    state_d = ST_GRANT;
                end
            end
            ST_GRANT: begin
                // Requester data is only guaranteed valid while gnt is high.
                data_d  = data_in[int'(win_q)*DATA_W +: DATA_W];
                last_d  = win_q;
                cnt_d   = HOLD_W'(HOLD_CYC - 1);
                state_d = ST_HOLD;
            end
            ST_HOLD: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - HOLD_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            win_q   <= '0;
            last_q  <= ID_W'(NREQ - 1);
            cnt_q   <= '0;
            data_q  <= RST_VAL;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        gnt = '0;
        if (state_q == ST_GRANT) begin
            gnt[win_q] = 1'b1;
        end
    end

    assign reg_data  = data_q;
    assign reg_valid = (state_q == ST_HOLD);
    assign busy      = (state_q != ST_IDLE);
    assign last_id   = last_q;

`ifdef REG_ARB_STATS_EN
    logic [15:0] gcnt_q [NREQ];
    logic [15:0] gcnt_d [NREQ];

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            gcnt_d[i] = gcnt_q[i];
            if (stats_clr) begin
                gcnt_d[i] = '0;
            end else if (gnt[i] && gcnt_q[i] != 16'hFFFF) begin
                gcnt_d[i] = gcnt_q[i] + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREQ; i++) begin
                gcnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                gcnt_q[i] <= gcnt_d[i];
            end
        end
    end

    always_comb begin
        grant_cnt = '0;
        for (int i = 0; i < NREQ; i++) begin
            grant_cnt[i*16 +: 16] = gcnt_q[i];
        end
    end
`endif

endmodule

// File: doc/reg_write_arbiter.md
Name: reg_write_arbiter

Overview:
- Round-robin arbiter that shares one 32-bit pipeline data register (the MemoriaReg write path) between NREQ requesters.
- The shared register has no write enable. It samples its input on every clk edge. This block therefore drives a registered data bus and holds it stable for a programmable number of cycles after each grant, so the register and its consumers see one clean value per transaction.
- Sits between the requesting units (ALU result, load unit, immediate path, debug) and the register's DataIn.

Parameters:
- NREQ, 4, number of requesters; legal range 2..8.
- DATA_W, 32, data width of each requester and of the shared register.
- HOLD_CYC, 2, cycles reg_data is held after a grant; legal range 1..15.
- RST_VAL, 0, value driven on reg_data during and after reset.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous reset, active-low; deassertion is synchronous to clk.
- req  input  NREQ  per-requester request level; held high until the matching gnt pulse.
- data_in  input  NREQ*DATA_W  packed request data; requester i occupies bits [i*DATA_W +: DATA_W].
- gnt  output  NREQ  one-hot, single-cycle acknowledge pulse to the winning requester.
- reg_data  output  DATA_W  registered data bus that drives the shared register's DataIn.
- reg_valid  output  1  high while reg_data carries a granted value (HOLD state).
- busy  output  1  high when not in IDLE.
- last_id  output  clog2(NREQ)  index of the most recent winner.

Behaviour:
- Reset (rst_n low, asynchronous):
  - gnt=0, reg_data=RST_VAL, reg_valid=0, busy=0, last_id=NREQ-1.
  - FSM goes to IDLE; hold counter=0.
  - The first arbitration after reset therefore starts at requester 0.
- FSM states: IDLE, GRANT, HOLD.
- IDLE:
  - If req==0, stay in IDLE.
  - Otherwise select the winner w: the first set req bit searching upward from (last_id+1) mod NREQ, with wrap-around.
  - At the edge: capture w into an internal winner register; go to GRANT.
- GRANT (exactly one cycle):
  - reg_data <= data_in[w] at this edge, so the new value appears on the following cycle.
  - gnt[w]=1 combinationally during GRANT only.
  - last_id <= w; counter <= HOLD_CYC-1; go to HOLD.
  - Requester w must drop req, or present new data, after sampling gnt. Its data only needs to be valid during GRANT.
- HOLD:
  - reg_valid=1; reg_data is unchanged.
  - Counter decrements each cycle. When it reaches 0, go to IDLE with reg_valid falling on the next cycle.
  - reg_data keeps its last value in IDLE; it is not cleared.
- Latency: req rising in IDLE -> gnt after 1 cycle -> reg_data updated the cycle after gnt.
- Transaction period: HOLD_CYC+2 cycles (IDLE, GRANT, HOLD_CYC).
- Requests arriving or dropping during GRANT/HOLD are ignored until IDLE. A requester that drops req before its grant simply loses its turn; there is no error.
- Simultaneous requests: resolved only by round-robin order relative to last_id. No requester is granted twice while another continuously requests.
- Single continuous requester: it is granted back-to-back, every HOLD_CYC+2 cycles.
- Reset mid-transaction: the transaction is aborted immediately, no gnt is emitted, and reg_data returns to RST_VAL.
- No X on outputs after reset, regardless of data_in.

Optional Feature:
- Macro: REG_ARB_STATS_EN.
- With it defined:
  - Adds output grant_cnt (NREQ*16 bits), one saturating 16-bit counter per requester.
  - Each counter increments on that requester's gnt pulse and saturates at 16'hFFFF.
  - Adds input stats_clr (1 bit); when high, all counters clear synchronously, with priority over an increment in the same cycle.
  - Counters reset to 0 on rst_n.
- Without it: neither port exists, no counter logic is built, and the remaining behaviour is identical.

Decomposition:
- Shared package reg_arb_pkg holds:
  - FSM state encoding (IDLE=2'd0, GRANT=2'd1, HOLD=2'd2);
  - the clog2 helper function;
  - the counter width constant HOLD_W=4.
- One natural sub-module, rr_pick: purely combinational. Inputs are req and last_id; outputs are the winner index and an any_req flag. It is instantiated once and unit-tested standalone.

Test Plan:
- Reset check: hold rst_n low and drive req=4'b1111 -> gnt=0, reg_data=0, busy=0; release -> first gnt=4'b0001.
- Single request: req[1]=1, data_in[1]=64 -> gnt=4'b0010 for exactly 1 cycle; reg_data=64 the next cycle; reg_valid high for 2 cycles (HOLD_CYC=2); then IDLE.
- Round-robin: req=4'b1111 held, data 64/128/256/512 on requesters 0..3 -> grant order 0,1,2,3,0 every 4 cycles; reg_data follows 64,128,256,512,64.
- Wrap and skip: last_id=2, req=4'b0011 -> next grant goes to 0, then 1; requester 2 is never granted.
- Mid-transaction reset: assert rst_n low during HOLD with reg_data=128 -> reg_data=0 asynchronously, and no gnt after release until a new req.
- REG_ARB_STATS_EN build: 3 grants to requester 2 -> grant_cnt slice 2 = 3; stats_clr together with a grant pulse -> counter reads 0.
